// File: rtl/round_controller.sv
// round_controller: door-guessing game round sequencer (doors, lives, positions, reveal timing)
module round_controller #(
    parameter int unsigned REVEAL_CYCLES = 50_000_000,
    parameter int unsigned SELECT_CYCLES = 500_000_000,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_left,
    input  logic       p1_right,
    input  logic       p1_confirm,
    input  logic       p2_left,
    input  logic       p2_right,
    input  logic       p2_confirm,
    output logic [1:0] correct_door_1,
    output logic [1:0] correct_door_2,
    output logic [1:0] player_1_pos,
    output logic [1:0] player_2_pos,
    output logic [1:0] p1_lives,
    output logic [1:0] p2_lives,
    output logic       resume,
    output logic       game_over,
    output logic [1:0] winner
);
    typedef enum logic [2:0] {IDLE, SELECT, REVEAL, SCORE, GAME_OVER} state_t;
    state_t state, state_n;
    logic [6:0] btn, btn_q, ev;
    logic [7:0] lfsr;
    logic [31:0] timer, timer_n, reveal_cnt, reveal_cnt_n;
    logic p1_lock, p2_lock, lock1_n, lock2_n, p1_lock_ev, p2_lock_ev;
    logic [1:0] d1_n, d2_n, pos1_n, pos2_n, l1_n, l2_n, win_n;
    logic [1:0] l1_dec, l2_dec, new_d1, new_d2;
    logic resume_n, go_n, sel_done, reveal_done, p1_miss, p2_miss, lost, setup;

    // saturating one-step move; simultaneous left and right cancel out
    function automatic logic [1:0] step(input logic [1:0] pos, input logic l, input logic r);
        return (l && !r && pos != 2'd0) ? pos - 2'd1 : (r && !l && pos != 2'd3) ? pos + 2'd1 : pos;
    endfunction

    assign btn = {start, p2_confirm, p2_right, p2_left, p1_confirm, p1_right, p1_left};
    assign ev = btn & ~btn_q;
    assign p1_lock_ev = p1_lock | ev[2];
    assign p2_lock_ev = p2_lock | ev[5];
    assign sel_done = (p1_lock_ev && p2_lock_ev) || timer == SELECT_CYCLES - 1;
    assign reveal_done = reveal_cnt == REVEAL_CYCLES - 1;
    assign p1_miss = player_1_pos != correct_door_1 && player_1_pos != correct_door_2;
    assign p2_miss = player_2_pos != correct_door_1 && player_2_pos != correct_door_2;
    assign l1_dec = (p1_miss && p1_lives != 2'd0) ? p1_lives - 2'd1 : p1_lives;
    assign l2_dec = (p2_miss && p2_lives != 2'd0) ? p2_lives - 2'd1 : p2_lives;
    assign lost = l1_dec == 2'd0 || l2_dec == 2'd0;
    assign new_d1 = lfsr[1:0];
    assign new_d2 = lfsr[3:2] == lfsr[1:0] ? lfsr[1:0] + 2'd1 : lfsr[3:2];
    assign setup = state_n == SELECT && state != SELECT;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // next-state decision
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = ev[6] ? SELECT : IDLE;
            SELECT:    state_n = sel_done ? REVEAL : SELECT;
            REVEAL:    state_n = reveal_done ? SCORE : REVEAL;
            SCORE:     state_n = lost ? GAME_OVER : SELECT;
            GAME_OVER: state_n = ev[6] ? IDLE : GAME_OVER;
            default:   state_n = IDLE;
        endcase
    end

    // next values of the registered outputs, timers and lock flags
    always_comb begin
        d1_n = correct_door_1;
        d2_n = correct_door_2;
        pos1_n = player_1_pos;
        pos2_n = player_2_pos;
        l1_n = p1_lives;
        l2_n = p2_lives;
        resume_n = resume;
        go_n = game_over;
        win_n = winner;
        lock1_n = p1_lock;
        lock2_n = p2_lock;
        timer_n = 32'd0;
        reveal_cnt_n = 32'd0;
        if (state == IDLE && ev[6]) begin
            l1_n = 2'd3;
            l2_n = 2'd3;
        end
        if (state == SELECT) begin
            timer_n = timer + 32'd1;
            pos1_n = p1_lock_ev ? player_1_pos : step(player_1_pos, ev[0], ev[1]);
            pos2_n = p2_lock_ev ? player_2_pos : step(player_2_pos, ev[3], ev[4]);
            lock1_n = p1_lock_ev | sel_done;
            lock2_n = p2_lock_ev | sel_done;
            timer_n = sel_done ? 32'd0 : timer_n;
            resume_n = !sel_done;
        end
        if (state == REVEAL) begin
            reveal_cnt_n = reveal_done ? 32'd0 : reveal_cnt + 32'd1;
            resume_n = reveal_done;
        end
        if (state == SCORE) begin
            l1_n = l1_dec;
            l2_n = l2_dec;
            go_n = lost;
            win_n = lost ? {l1_dec == 2'd0, l2_dec == 2'd0} : 2'b00;
        end
        if (state == GAME_OVER && ev[6]) begin
            go_n = 1'b0;
            win_n = 2'b00;
        end
        if (setup) begin
            pos1_n = 2'd0;
            pos2_n = 2'd0;
            lock1_n = 1'b0;
            lock2_n = 1'b0;
            timer_n = 32'd0;
            d1_n = new_d1;
            d2_n = new_d2;
        end
    end

    // datapath registers: button history, LFSR, timers, locks and all outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q <= '0;
            lfsr <= LFSR_SEED;
            timer <= '0;
            reveal_cnt <= '0;
            p1_lock <= 1'b0;
            p2_lock <= 1'b0;
            correct_door_1 <= 2'd0;
            correct_door_2 <= 2'd1;
            player_1_pos <= 2'd0;
            player_2_pos <= 2'd0;
            p1_lives <= 2'd3;
            p2_lives <= 2'd3;
            resume <= 1'b1;
            game_over <= 1'b0;
            winner <= 2'b00;
        end else begin
            btn_q <= btn;
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            timer <= timer_n;
            reveal_cnt <= reveal_cnt_n;
            p1_lock <= lock1_n;
            p2_lock <= lock2_n;
            correct_door_1 <= d1_n;
            correct_door_2 <= d2_n;
            player_1_pos <= pos1_n;
            player_2_pos <= pos2_n;
            p1_lives <= l1_n;
            p2_lives <= l2_n;
            resume <= resume_n;
            game_over <= go_n;
            winner <= win_n;
        end
    end
endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller: scoreboard bench for the round sequencer
module tb_round_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [5:0] btn = 6'd0;
    logic [1:0] cd1, cd2, pp1, pp2, l1, l2, win;
    logic res, go;
    int total = 0;
    int bad = 0;
    string tq[$];
    logic [15:0] vq[$];
    string t;
    logic [15:0] v;
    logic [7:0] m_lfsr;
    logic [1:0] x_d1, x_d2, x_p1, x_p2, x_l1, x_l2;
    localparam logic [5:0] P1L = 6'd1, P1R = 6'd2, P1C = 6'd4, P2L = 6'd8, P2R = 6'd16, P2C = 6'd32;

    round_controller #(.REVEAL_CYCLES(4), .SELECT_CYCLES(20), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .reset(reset), .start(start),
        .p1_left(btn[0]), .p1_right(btn[1]), .p1_confirm(btn[2]),
        .p2_left(btn[3]), .p2_right(btn[4]), .p2_confirm(btn[5]),
        .correct_door_1(cd1), .correct_door_2(cd2),
        .player_1_pos(pp1), .player_2_pos(pp2),
        .p1_lives(l1), .p2_lives(l2),
        .resume(res), .game_over(go), .winner(win)
    );

    always #5 clk = ~clk;

    // reference LFSR, used to predict the doors picked at each round setup
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    function automatic logic [15:0] obs();
        return {cd1, cd2, pp1, pp2, l1, l2, res, go, win};
    endfunction

    function automatic logic [15:0] cur(input logic r, input logic g, input logic [1:0] w);
        return {x_d1, x_d2, x_p1, x_p2, x_l1, x_l2, r, g, w};
    endfunction

    function automatic logic [1:0] nd2(input logic [7:0] l);
        return l[3:2] == l[1:0] ? l[1:0] + 2'd1 : l[3:2];
    endfunction

    task automatic push_exp(input string tag, input logic [15:0] val);
        tq.push_back(tag);
        vq.push_back(val);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [5:0] b);
        btn = b;
        tick();
        btn = 6'd0;
        tick();
    endtask

    task automatic new_game_expect();
        x_d1 = m_lfsr[1:0];
        x_d2 = nd2(m_lfsr);
        x_p1 = 2'd0;
        x_p2 = 2'd0;
        x_l1 = 2'd3;
        x_l2 = 2'd3;
    endtask

    task automatic move_both(input logic [1:0] a, input logic [1:0] b);
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < a || 2'(i) < b)
                press((2'(i) < a ? P1R : 6'd0) | (2'(i) < b ? P2R : 6'd0));
        end
        x_p1 = a;
        x_p2 = b;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        push_exp("reset_async", {2'd0, 2'd1, 2'd0, 2'd0, 2'd3, 2'd3, 1'b1, 1'b0, 2'd0});
        #2;
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
        tick();
        tick();
        reset = 1'b1;
        push_exp("reset_idle_hold", {2'd0, 2'd1, 2'd0, 2'd0, 2'd3, 2'd3, 1'b1, 1'b0, 2'd0});
        tick();
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
    endtask

    task automatic test_start();
        new_game_expect();
        start = 1'b1;
        push_exp("start_select", cur(1'b1, 1'b0, 2'd0));
        tick();
        start = 1'b0;
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
        total++;
        if (cd1 === cd2) begin bad++; $display("FAIL doors_distinct got=%0d/%0d exp=different", cd1, cd2); end
        push_exp("select_steady", cur(1'b1, 1'b0, 2'd0));
        tick();
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
    endtask

    task automatic test_move();
        for (int i = 1; i <= 4; i++) begin
            x_p1 = i > 3 ? 2'd3 : 2'(i);
            push_exp("p1_right", cur(1'b1, 1'b0, 2'd0));
            press(P1R);
            t = tq.pop_front(); v = vq.pop_front(); total++;
            if (obs() !== v) begin bad++; $display("FAIL %s #%0d got=%h exp=%h", t, i, obs(), v); end
        end
        push_exp("left_right_cancel_p2_left_sat", cur(1'b1, 1'b0, 2'd0));
        press(P1L | P1R | P2L);
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
    endtask

    task automatic test_lock();
        push_exp("confirm_with_right", cur(1'b1, 1'b0, 2'd0));
        press(P1C | P1R);
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
        push_exp("locked_ignores_left", cur(1'b1, 1'b0, 2'd0));
        press(P1L);
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
        btn = P2C;
        tick();
        btn = 6'd0;
        test_reveal_score();
    endtask

    // entered one step after the edge that left SELECT
    task automatic test_reveal_score();
        logic m1, m2;
        for (int i = 0; i < 4; i++) begin
            push_exp("reveal_open", cur(1'b0, 1'b0, 2'd0));
            t = tq.pop_front(); v = vq.pop_front(); total++;
            if (obs() !== v) begin bad++; $display("FAIL %s cycle %0d got=%h exp=%h", t, i, obs(), v); end
            tick();
        end
        push_exp("score_closed", cur(1'b1, 1'b0, 2'd0));
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
        m1 = x_p1 != x_d1 && x_p1 != x_d2;
        m2 = x_p2 != x_d1 && x_p2 != x_d2;
        if (m1 && x_l1 != 2'd0) x_l1 = x_l1 - 2'd1;
        if (m2 && x_l2 != 2'd0) x_l2 = x_l2 - 2'd1;
        if (x_l1 == 2'd0 || x_l2 == 2'd0) begin
            push_exp("score_game_over", cur(1'b1, 1'b1, {x_l1 == 2'd0, x_l2 == 2'd0}));
        end else begin
            x_d1 = m_lfsr[1:0];
            x_d2 = nd2(m_lfsr);
            x_p1 = 2'd0;
            x_p2 = 2'd0;
            push_exp("next_round", cur(1'b1, 1'b0, 2'd0));
        end
        tick();
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
    endtask

    task automatic test_both_correct();
        move_both(x_d1, x_d2);
        push_exp("moved_to_correct", cur(1'b1, 1'b0, 2'd0));
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
        btn = P1C | P2C;
        tick();
        btn = 6'd0;
        test_reveal_score();
    endtask

    task automatic test_game_over();
        logic [1:0] w;
        reset = 1'b0;
        #2 reset = 1'b1;
        new_game_expect();
        x_d1 = 2'd1;
        x_d2 = 2'd2;
        start = 1'b1;
        push_exp("seed_doors_collision", cur(1'b1, 1'b0, 2'd0));
        tick();
        start = 1'b0;
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
        for (int r = 0; r < 3; r++) begin
            w = 2'd0;
            for (int k = 3; k >= 0; k--) if (2'(k) != x_d1 && 2'(k) != x_d2) w = 2'(k);
            move_both(w, x_d1);
            btn = P1C | P2C;
            tick();
            btn = 6'd0;
            test_reveal_score();
            total++;
            if (l1 !== 2'(2 - r)) begin bad++; $display("FAIL p1_lives_round%0d got=%0d exp=%0d", r, l1, 2 - r); end
        end
        total++;
        if ({go, win, l2} !== {1'b1, 2'b10, 2'd3}) begin
            bad++; $display("FAIL game_over_p2_wins got go=%b win=%b l2=%0d exp go=1 win=10 l2=3", go, win, l2);
        end
        push_exp("game_over_ignores_buttons", cur(1'b1, 1'b1, 2'b10));
        press(P1R | P2L | P1C);
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
        start = 1'b1;
        push_exp("game_over_to_idle", cur(1'b1, 1'b0, 2'b00));
        tick();
        start = 1'b0;
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
        tick();
    endtask

    task automatic test_timeout();
        new_game_expect();
        start = 1'b1;
        push_exp("idle_restart_lives", cur(1'b1, 1'b0, 2'd0));
        tick();
        start = 1'b0;
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
        x_p1 = 2'd1;
        push_exp("timeout_p1_right", cur(1'b1, 1'b0, 2'd0));
        press(P1R);
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
        for (int k = 3; k <= 20; k++) begin
            push_exp("select_timeout", cur(k != 20, 1'b0, 2'd0));
            tick();
            t = tq.pop_front(); v = vq.pop_front(); total++;
            if (obs() !== v) begin bad++; $display("FAIL %s edge %0d got=%h exp=%h", t, k, obs(), v); end
        end
        push_exp("reveal_after_timeout", cur(1'b0, 1'b0, 2'd0));
        press(P1R | P2R);
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
        #2 reset = 1'b0;
        push_exp("reset_mid_reveal", {2'd0, 2'd1, 2'd0, 2'd0, 2'd3, 2'd3, 1'b1, 1'b0, 2'd0});
        #1;
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
        tick();
        reset = 1'b1;
        tick();
        tick();
        new_game_expect();
        start = 1'b1;
        push_exp("post_reset_start", cur(1'b1, 1'b0, 2'd0));
        tick();
        start = 1'b0;
        t = tq.pop_front(); v = vq.pop_front(); total++;
        if (obs() !== v) begin bad++; $display("FAIL %s got=%h exp=%h", t, obs(), v); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_move();
        test_lock();
        test_both_correct();
        test_game_over();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/round_controller.md
# round_controller

Game-round sequencer for the door-guessing game; drives the door, lives, player-position and resume inputs of `screen_drawer`. Picks two distinct correct doors per round from an internal LFSR, lets both players move and lock a door choice, holds the doors open for a reveal window, deducts lives and detects game over. All outputs are registered and remain stable between state changes, so the pixel pipeline can sample them at any time.

## Interface
- `REVEAL_CYCLES`, 50_000_000: cycles that `resume` stays low (doors shown open).
- `SELECT_CYCLES`, 500_000_000: selection timeout in cycles.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; rising edge starts a game or leaves GAME_OVER.
- `p1_left`, `p1_right`, `p1_confirm`  in  1 each  player 1 buttons, debounced level signals.
- `p2_left`, `p2_right`, `p2_confirm`  in  1 each  player 2 buttons, same rules.
- `correct_door_1`, `correct_door_2`  out  2 each  correct doors for the round; always distinct.
- `player_1_pos`, `player_2_pos`  out  2 each  door index each player is on.
- `p1_lives`, `p2_lives`  out  2 each  remaining lives, 0..3.
- `resume`  out  1  0 = doors shown open (reveal); 1 = doors closed.
- `game_over`  out  1  high in GAME_OVER.
- `winner`  out  2  00 none, 01 P1, 10 P2, 11 draw; valid while `game_over` is high.

## Operation
- Every button input is edge-detected with a one-register history, which resets to 0. An "event" is a rising edge: the signal is sampled 1 while its history is 0.
- LFSR: 8 bits, reset to `LFSR_SEED`, shifts left every cycle in every state. Feedback bit = `lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]`.
- States: IDLE, SELECT, REVEAL, SCORE, GAME_OVER.
- IDLE: on a `start` event, go to SELECT, reload both lives to 3, and run the round setup.
- Round setup (on every entry to SELECT):
  - Clear both positions to 0 and both lock flags.
  - Clear the select timer.
  - `correct_door_1 = lfsr[1:0]`.
  - `correct_door_2 = lfsr[3:2]`; if it equals door 1, use `lfsr[1:0]+1` instead (2-bit wrap, so 3 becomes 0).
- SELECT, applied per player while that player is unlocked:
  - A confirm event sets the lock flag. Any move event in the same cycle is ignored.
  - A left event alone decrements the position, saturating at 0.
  - A right event alone increments the position, saturating at 3.
  - Left and right events in the same cycle: no move.
  - Locked players ignore all buttons.
- SELECT exit: when both players are locked, or the timer reaches `SELECT_CYCLES-1`, go to REVEAL. On timeout, unlocked players are force-locked at their current position. Clear the timer on exit.
- REVEAL: `resume`=0. After `REVEAL_CYCLES` cycles, go to SCORE.
- SCORE (1 cycle): a player whose position matches neither correct door loses one life, saturating at 0. Both players may lose a life in the same cycle.
- After SCORE:
  - If either player's decremented lives is 0, go to GAME_OVER and set `winner`: 01 if only P2 is at 0, 10 if only P1 is at 0, 11 if both are at 0.
  - Otherwise, go to SELECT with the round setup.
- GAME_OVER: positions, doors and lives hold. On a `start` event, go to IDLE; `winner` clears to 00 and `game_over` to 0.
- `start` is ignored outside IDLE and GAME_OVER. Buttons are ignored outside SELECT.
- Reset (asserted at any time, including mid-REVEAL) forces the reset values below immediately and asynchronously.
- Reset values:
  - state IDLE
  - `correct_door_1`=0, `correct_door_2`=1
  - both positions 0
  - both lives 3
  - `resume`=1
  - `game_over`=0
  - `winner`=00
  - LFSR = `LFSR_SEED`
  - timers 0

## Timing
- The rising edge that samples an event also performs the state or output update; outputs change right after that edge.
- A `start` event sampled at edge k puts state SELECT and the new doors on the outputs after edge k.
- The edge that leaves SELECT drives `resume` to 0. `resume` stays 0 for exactly `REVEAL_CYCLES` cycles, then the controller is in SCORE for 1 cycle with `resume`=1.
- The edge leaving SCORE updates lives. It also updates either the new doors (next round) or `game_over`/`winner`.
- From both-locked to the next round in SELECT: `REVEAL_CYCLES`+1 cycles.
- SELECT timeout: the exit edge occurs `SELECT_CYCLES` cycles after SELECT entry.
- The timer is 32 bits wide. Parameters must be ≥1 and < 2^32.

## Test plan
All scenarios use `REVEAL_CYCLES`=4, `SELECT_CYCLES`=20, `LFSR_SEED`=8'hA5.
- Reset, then a `start` pulse → SELECT; lives 3/3; positions 0/0; `resume`=1. Doors match the LFSR value at the start edge and differ from each other.
- P1: right×3, then right again → position 3 (saturates). Left and right pulsed together → position unchanged.
- P1 confirm together with right → P1 locked at its old position. Later P1 presses are ignored.
- Both players lock on correct doors → `resume` low for exactly 4 cycles, SCORE, lives stay 3/3, new round starts.
- P1 on a wrong door, P2 on a correct door, repeated 3 rounds → `p1_lives` 2, 1, 0; `game_over`=1, `winner`=10. A `start` pulse → IDLE, `winner`=00.
- No confirms → timeout after 20 cycles, both auto-locked at their positions, REVEAL follows. Reset asserted mid-REVEAL → all outputs at reset values on the same edge/asynchronously.
